game_tick_scheduler: RTL and testbench
======================================

Name: game_tick_scheduler

Overview:
- Central timing controller for the PONG game logic; replaces per-module free-running dividers with one shared prescaler.
- Produces single-cycle clock-enable strobes in the i_clk domain: base tick, paddle update, ball update.
- Sequences game phases (stopped, serve hold, running).
- Ramps ball speed as paddle hits accumulate; restores default speed on each serve.

Parameters:
INPUT_CLOCK, 25000000, i_clk frequency in Hz
BASE_TICK, 1000, base tick rate in Hz; PRESCALE = INPUT_CLOCK/BASE_TICK (integer division, must be >= 2)
PADDLE_MS, 10, paddle strobe period in base ticks (>= 1)
BALL_MS_MAX, 20, ball strobe period after reset or serve, in base ticks
BALL_MS_MIN, 5, fastest ball period in base ticks (1 <= MIN <= MAX)
SPEEDUP_HITS, 4, paddle hits per one-tick period decrement (>= 1)
SERVE_MS, 500, base ticks spent in HOLD before the ball moves (>= 1)

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous reset, active-high
i_run  input  1  level; 1 = game active, 0 = pause/stop
i_serve  input  1  one-cycle pulse; start new round
i_hit  input  1  one-cycle pulse; ball struck a paddle
o_base_tick  output  1  one-cycle strobe at BASE_TICK rate
o_paddle_en  output  1  one-cycle paddle-update strobe
o_ball_en  output  1  one-cycle ball-update strobe
o_ball_period  output  $clog2(BALL_MS_MAX+1)  current ball period in base ticks
o_state  output  2  0 = STOPPED, 1 = HOLD, 2 = RUNNING

Behaviour:
- Reset (i_rst=1 at posedge):
  - state = STOPPED; all counters = 0; hit_cnt = 0.
  - o_ball_period = BALL_MS_MAX; all strobes = 0.
  - i_rst takes priority over every other input, including mid-round.
- All outputs are registered.
- Prescaler:
  - In STOPPED: held at 0.
  - Otherwise: counts 0..PRESCALE-1 and wraps.
  - o_base_tick = 1 on the cycle after the counter is at PRESCALE-1, i.e. the first strobe comes PRESCALE cycles after leaving STOPPED.
- Paddle counter:
  - Advances on each base tick in HOLD or RUNNING; wraps at PADDLE_MS-1.
  - o_paddle_en asserts in the same cycle as the o_base_tick that causes the wrap.
- Ball counter:
  - Advances on base ticks in RUNNING only; held at 0 in HOLD and STOPPED.
  - Wraps when count >= o_ball_period-1, so the new period takes effect without overshoot if it shrinks mid-count.
  - o_ball_en asserts coincident with that base tick.
- Hold counter:
  - Counts base ticks in HOLD; cleared on HOLD entry.
  - On the SERVE_MS-th base tick in HOLD -> RUNNING.
  - No o_ball_en is issued on that same tick.
- State transitions, highest priority first:
  - any state, i_run=0 -> STOPPED. Prescaler, paddle, ball and hold counters are cleared; o_ball_period and hit_cnt are retained (pause).
  - STOPPED, i_run=1 -> HOLD.
  - HOLD or RUNNING, i_serve=1 -> HOLD. Hold counter restarts; o_ball_period = BALL_MS_MAX; hit_cnt = 0; prescaler and paddle counter keep running.
  - HOLD, hold expiry -> RUNNING.
- i_serve in STOPPED is ignored.
- Speed-up:
  - i_hit counts only in RUNNING and only when i_serve is low (serve wins on a simultaneous pulse).
  - If hit_cnt == SPEEDUP_HITS-1: hit_cnt = 0 and o_ball_period = max(o_ball_period-1, BALL_MS_MIN).
  - Otherwise hit_cnt increments.
  - At BALL_MS_MIN the period saturates; hits keep cycling hit_cnt.
- Outputs in STOPPED: o_base_tick, o_paddle_en and o_ball_en are 0 from the cycle after i_run falls.

Test Plan:
Bench parameters: INPUT_CLOCK=100, BASE_TICK=10 (PRESCALE=10), PADDLE_MS=2, BALL_MS_MAX=4, BALL_MS_MIN=2, SPEEDUP_HITS=2, SERVE_MS=3.
1. Reset, then i_run=1 -> o_state=1 next cycle; o_base_tick every 10 cycles, first 10 cycles after HOLD entry; o_paddle_en every 20; no o_ball_en during 3 ticks; o_state=2 on the 3rd tick; o_ball_en every 40 cycles thereafter.
2. In RUNNING, pulse i_hit 6 times -> o_ball_period steps 4->3 after hit 2, 3->2 after hit 4, stays 2 after hit 6; o_ball_en spacing becomes 30 and then 20 cycles.
3. With period 2, pulse i_serve -> o_state=1, o_ball_period=4, no o_ball_en for 3 base ticks, paddle strobes uninterrupted.
4. i_run=0 mid-RUNNING with period 3 -> next cycle o_state=0, all strobes 0, o_ball_period=3; i_run=1 -> HOLD, first o_base_tick 10 cycles later.
5. i_hit and i_serve in the same cycle while RUNNING with hit_cnt=1 -> o_ball_period=4, o_state=1, the following single hit does not change the period.
6. i_rst asserted for one cycle mid-HOLD and mid-RUNNING -> next cycle o_state=0, o_ball_period=4, strobes 0; i_serve pulses while STOPPED are ignored.

Source files
------------

// File: rtl/game_tick_scheduler.sv
// Shared timing controller for the PONG game logic: one prescaler feeding base,
// paddle and ball clock-enable strobes, plus round sequencing and ball speed-up.
module game_tick_scheduler #(
    parameter int INPUT_CLOCK  = 25000000,
    parameter int BASE_TICK    = 1000,
    parameter int PADDLE_MS    = 10,
    parameter int BALL_MS_MAX  = 20,
    parameter int BALL_MS_MIN  = 5,
    parameter int SPEEDUP_HITS = 4,
    parameter int SERVE_MS     = 500
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_run,
    input  logic                               i_serve,
    input  logic                               i_hit,
    output logic                               o_base_tick,
    output logic                               o_paddle_en,
    output logic                               o_ball_en,
    output logic [$clog2(BALL_MS_MAX+1)-1:0]   o_ball_period,
    output logic [1:0]                         o_state
);

    localparam int PRESCALE = INPUT_CLOCK / BASE_TICK;
    localparam int BW  = $clog2(BALL_MS_MAX + 1);
    localparam int PW  = (PRESCALE > 1)     ? $clog2(PRESCALE)     : 1;
    localparam int PDW = (PADDLE_MS > 1)    ? $clog2(PADDLE_MS)    : 1;
    localparam int HDW = (SERVE_MS > 1)     ? $clog2(SERVE_MS)     : 1;
    localparam int SW  = (SPEEDUP_HITS > 1) ? $clog2(SPEEDUP_HITS) : 1;

    localparam logic [PW-1:0]  PRE_LAST    = PW'(PRESCALE - 1);
    localparam logic [PDW-1:0] PADDLE_LAST = PDW'(PADDLE_MS - 1);
    localparam logic [HDW-1:0] HOLD_LAST   = HDW'(SERVE_MS - 1);
    localparam logic [SW-1:0]  HIT_LAST    = SW'(SPEEDUP_HITS - 1);
    localparam logic [BW-1:0]  PERIOD_MAX  = BW'(BALL_MS_MAX);
    localparam logic [BW-1:0]  PERIOD_MIN  = BW'(BALL_MS_MIN);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RUNNING = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_pre;
    logic [PDW-1:0]  r_paddle_cnt;
    logic [HDW-1:0]  r_hold_cnt;
    logic [BW-1:0]   r_ball_cnt;
    logic [BW-1:0]   r_ball_period;
    logic [SW-1:0]   r_hit_cnt;
    logic            r_base_tick;
    logic            r_paddle_en;
    logic            r_ball_en;

    logic w_active;
    logic w_tick;
    logic w_serve;
    logic w_run_live;
    logic w_hold_done;
    logic w_paddle_wrap;
    logic w_ball_wrap;
    logic w_hit_take;

    // A dropped i_run suppresses strobes on the very edge it is sampled.
    assign w_active      = i_run && (r_state != ST_STOPPED);
    assign w_tick        = w_active && (r_pre == PRE_LAST);
    assign w_serve       = w_active && i_serve;
    assign w_run_live    = i_run && !i_serve && (r_state == ST_RUNNING);
    assign w_hold_done   = i_run && !i_serve && (r_state == ST_HOLD) && w_tick
                           && (r_hold_cnt == HOLD_LAST);
    assign w_paddle_wrap = w_tick && (r_paddle_cnt == PADDLE_LAST);
    // Compare against the live period so a shrink mid-count never overshoots.
    assign w_ball_wrap   = w_run_live && w_tick
                           && ((r_ball_cnt + BW'(1)) >= r_ball_period);
    assign w_hit_take    = w_run_live && i_hit;

    // NOTE: default assignment first keeps this purely combinational (no latch).
    always_comb begin
        w_state_nxt = r_state;
        if (!i_run) begin
            w_state_nxt = ST_STOPPED;
        end else begin
            case (r_state)
                ST_STOPPED: w_state_nxt = ST_HOLD;
                ST_HOLD:    if (i_serve)          w_state_nxt = ST_HOLD;
                            else if (w_hold_done) w_state_nxt = ST_RUNNING;
                ST_RUNNING: if (i_serve)          w_state_nxt = ST_HOLD;
                default:    w_state_nxt = ST_STOPPED;
            endcase
        end
    end

    // NOTE: non-blocking assignments for all registered state.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_STOPPED;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pre         <= '0;
            r_paddle_cnt  <= '0;
            r_hold_cnt    <= '0;
            r_ball_cnt    <= '0;
            r_hit_cnt     <= '0;
            r_ball_period <= PERIOD_MAX;
            r_base_tick   <= 1'b0;
            r_paddle_en   <= 1'b0;
            r_ball_en     <= 1'b0;
        end else begin
            r_base_tick <= w_tick;
            r_paddle_en <= w_paddle_wrap;
            r_ball_en   <= w_ball_wrap;

            if (!w_active || (r_pre == PRE_LAST)) r_pre <= '0;
            else                                  r_pre <= r_pre + PW'(1);

            if (!w_active)     r_paddle_cnt <= '0;
            else if (w_tick)   r_paddle_cnt <= w_paddle_wrap ? '0 : r_paddle_cnt + PDW'(1);

            if (!w_active || w_serve || (r_state != ST_HOLD)) r_hold_cnt <= '0;
            else if (w_tick) r_hold_cnt <= w_hold_done ? '0 : r_hold_cnt + HDW'(1);

            if (!w_run_live)   r_ball_cnt <= '0;
            else if (w_tick)   r_ball_cnt <= w_ball_wrap ? '0 : r_ball_cnt + BW'(1);

            if (w_serve) begin
                r_ball_period <= PERIOD_MAX;
                r_hit_cnt     <= '0;
            end else if (w_hit_take) begin
                if (r_hit_cnt == HIT_LAST) begin
                    r_hit_cnt <= '0;
                    if (r_ball_period > PERIOD_MIN) r_ball_period <= r_ball_period - BW'(1);
                end else begin
                    r_hit_cnt <= r_hit_cnt + SW'(1);
                end
            end
        end
    end

    assign o_base_tick   = r_base_tick;
    assign o_paddle_en   = r_paddle_en;
    assign o_ball_en     = r_ball_en;
    assign o_ball_period = r_ball_period;
    assign o_state       = r_state;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Self-checking bench: directed round scenarios followed by random play, every
// cycle compared against an elapsed-time reference model of the scheduler.
module tb_game_tick_scheduler;

    localparam int INPUT_CLOCK  = 100;
    localparam int BASE_TICK    = 10;
    localparam int PADDLE_MS    = 2;
    localparam int BALL_MS_MAX  = 4;
    localparam int BALL_MS_MIN  = 2;
    localparam int SPEEDUP_HITS = 2;
    localparam int SERVE_MS     = 3;
    localparam int PRESCALE     = INPUT_CLOCK / BASE_TICK;
    localparam int BW           = $clog2(BALL_MS_MAX + 1);

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          i_run = 1'b0;
    logic          i_serve = 1'b0;
    logic          i_hit = 1'b0;
    logic          o_base_tick;
    logic          o_paddle_en;
    logic          o_ball_en;
    logic [BW-1:0] o_ball_period;
    logic [1:0]    o_state;

    int n_checks = 0;
    int n_errors = 0;
    int n_cycle  = 0;

    // Reference model: time measured as cycles/ticks elapsed since the round went live.
    int m_state  = 0;
    int m_period = BALL_MS_MAX;
    int m_hits   = 0;
    int m_cyc    = 0;
    int m_ticks  = 0;
    int m_hold_start = 0;
    int m_last_ball  = 0;
    int e_bt = 0, e_pe = 0, e_be = 0;

    game_tick_scheduler #(
        .INPUT_CLOCK (INPUT_CLOCK),
        .BASE_TICK   (BASE_TICK),
        .PADDLE_MS   (PADDLE_MS),
        .BALL_MS_MAX (BALL_MS_MAX),
        .BALL_MS_MIN (BALL_MS_MIN),
        .SPEEDUP_HITS(SPEEDUP_HITS),
        .SERVE_MS    (SERVE_MS)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_run        (i_run),
        .i_serve      (i_serve),
        .i_hit        (i_hit),
        .o_base_tick  (o_base_tick),
        .o_paddle_en  (o_paddle_en),
        .o_ball_en    (o_ball_en),
        .o_ball_period(o_ball_period),
        .o_state      (o_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, n_cycle, obs, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit run, input bit serve, input bit hit);
        bit tick;
        e_bt = 0; e_pe = 0; e_be = 0;
        if (rst) begin
            m_state = 0; m_period = BALL_MS_MAX; m_hits = 0;
        end else if (!run) begin
            m_state = 0;
        end else if (m_state == 0) begin
            m_state = 1; m_cyc = 0; m_ticks = 0; m_hold_start = 0;
        end else begin
            m_cyc++;
            tick = (m_cyc % PRESCALE) == 0;
            if (tick) begin
                m_ticks++;
                e_bt = 1;
                e_pe = ((m_ticks % PADDLE_MS) == 0) ? 1 : 0;
            end
            if (serve) begin
                m_state = 1; m_hold_start = m_ticks; m_period = BALL_MS_MAX; m_hits = 0;
            end else if (m_state == 1) begin
                if (tick && (m_ticks - m_hold_start == SERVE_MS)) begin
                    m_state = 2; m_last_ball = m_ticks;
                end
            end else begin
                if (tick && (m_ticks - m_last_ball >= m_period)) begin
                    e_be = 1; m_last_ball = m_ticks;
                end
                if (hit) begin
                    if (m_hits == SPEEDUP_HITS - 1) begin
                        m_hits = 0;
                        if (m_period > BALL_MS_MIN) m_period--;
                    end else begin
                        m_hits++;
                    end
                end
            end
        end
    endtask

    task automatic cycle(input bit rst, input bit run, input bit serve, input bit hit);
        i_rst = rst; i_run = run; i_serve = serve; i_hit = hit;
        @(posedge i_clk);
        n_cycle++;
        model_step(rst, run, serve, hit);
        #1;
        check("state",       int'(o_state),       m_state);
        check("ball_period", int'(o_ball_period), m_period);
        check("base_tick",   int'(o_base_tick),   e_bt);
        check("paddle_en",   int'(o_paddle_en),   e_pe);
        check("ball_en",     int'(o_ball_en),     e_be);
    endtask

    task automatic idle(input int n, input bit run);
        for (int k = 0; k < n; k++) cycle(1'b0, run, 1'b0, 1'b0);
    endtask

    initial begin
        bit r_run;
        // 1: reset, then a full serve hold into running
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_state", int'(o_state), 0);
        check("rst_period", int'(o_ball_period), BALL_MS_MAX);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("enter_hold", int'(o_state), 1);
        idle(200, 1'b1);
        check("running", int'(o_state), 2);

        // 2: six hits ramp the period 4 -> 3 -> 2 and saturate
        for (int h = 0; h < 6; h++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b1);
            idle(14, 1'b1);
        end
        check("ramp_sat", int'(o_ball_period), BALL_MS_MIN);
        idle(80, 1'b1);

        // 3: serve restores default speed
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check("serve_state", int'(o_state), 1);
        check("serve_period", int'(o_ball_period), BALL_MS_MAX);
        idle(80, 1'b1);

        // 4: pause with period 3 retains the period
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        idle(5, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        idle(23, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("pause_state", int'(o_state), 0);
        check("pause_period", int'(o_ball_period), 3);
        idle(4, 1'b0);
        idle(60, 1'b1);

        // 5: hit coincident with serve loses to the serve
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        idle(3, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        check("hs_state", int'(o_state), 1);
        check("hs_period", int'(o_ball_period), BALL_MS_MAX);
        idle(40, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check("hs_single_hit", int'(o_ball_period), BALL_MS_MAX);
        idle(20, 1'b1);

        // 6: reset mid-round, and serve pulses while stopped
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        idle(12, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("rst_hold", int'(o_state), 0);
        idle(50, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        idle(5, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("rst_run_period", int'(o_ball_period), BALL_MS_MAX);
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, k[0], 1'b0);
        check("stopped_serve", int'(o_state), 0);

        // random play
        r_run = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 299) == 0) r_run = ~r_run;
            if (!r_run && $urandom_range(0, 19) == 0) r_run = 1'b1;
            cycle($urandom_range(0, 799) == 0, r_run,
                  $urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
